// File: rtl/pic_pkg.sv
// Shared definitions for the 8259 PIC host bus initiator:
// op codes, ICW/OCW bit positions and masks, FSM encodings.
package pic_pkg;

  localparam logic [2:0] OP_INIT   = 3'd0;
  localparam logic [2:0] OP_OCW1   = 3'd1;
  localparam logic [2:0] OP_OCW2   = 3'd2;
  localparam logic [2:0] OP_OCW3   = 3'd3;
  localparam logic [2:0] OP_RD_IRR = 3'd4;
  localparam logic [2:0] OP_RD_ISR = 3'd5;
  localparam logic [2:0] OP_RD_IMR = 3'd6;
  localparam logic [2:0] OP_RSVD   = 3'd7;

  localparam int ICW1_IC4  = 0;
  localparam int ICW1_SNGL = 1;
  localparam logic [7:0] ICW1_SET = 8'h10;

  localparam logic [7:0] OCW3_RR_IRR = 8'h0A;
  localparam logic [7:0] OCW3_RR_ISR = 8'h0B;
  localparam logic [7:0] OCW2_KEEP   = 8'hE7;
  localparam logic [7:0] OCW3_KEEP   = 8'h67;
  localparam logic [7:0] OCW3_SET    = 8'h08;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_HOLD,
    PH_RECOV
  } phase_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERR,
    ST_BUSY
  } state_t;

  typedef struct packed {
    logic       rd;
    logic       a0;
    logic [7:0] d;
  } bus_op_t;

  function automatic int max3(int a, int b, int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pic_host_bus_initiator_bus_cycle.sv
// pic_bus_cycle: one timed PIC bus cycle SETUP/STROBE/HOLD/RECOV.
// Ports: clk, rst, start, op (rd/a0/data), d_in -> cs_n, wr_n,
// rd_n, a0, d_out, d_oe, rdata, rvalid (pulse in RECOV), done.
module pic_bus_cycle
  import pic_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  bus_op_t    op,
  input  logic [7:0] d_in,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       a0,
  output logic [7:0] d_out,
  output logic       d_oe,
  output logic [7:0] rdata,
  output logic       rvalid,
  output logic       done
);

  localparam int CW =
    $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC)) + 1;

  phase_t        ph, ph_nx;
  logic [CW-1:0] cnt, cnt_nx;
  bus_op_t       cur;
  logic [7:0]    samp;
  logic          active;
  logic          last;

  assign last = (cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ph     <= PH_IDLE;
      cnt    <= '0;
      cur    <= '0;
      samp   <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      ph     <= ph_nx;
      cnt    <= cnt_nx;
      rvalid <= 1'b0;
      if (start && (ph == PH_IDLE || ph == PH_RECOV))
        cur <= op;
      if (ph == PH_STROBE && last && cur.rd)
        samp <= d_in;
      // publish the sample so the pulse lands in RECOV
      if (ph == PH_HOLD && last && cur.rd) begin
        rdata  <= samp;
        rvalid <= 1'b1;
      end
    end
  end

  always_comb begin
    ph_nx  = ph;
    cnt_nx = cnt;
    unique case (ph)
      PH_IDLE: begin
        if (start) begin
          ph_nx  = PH_SETUP;
          cnt_nx = CW'(SETUP_CYC - 1);
        end
      end
      PH_SETUP: begin
        if (last) begin
          ph_nx  = PH_STROBE;
          cnt_nx = CW'(STROBE_CYC - 1);
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      PH_STROBE: begin
        if (last) begin
          ph_nx  = PH_HOLD;
          cnt_nx = CW'(HOLD_CYC - 1);
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      PH_HOLD: begin
        if (last) begin
          ph_nx  = PH_RECOV;
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      PH_RECOV: begin
        if (start) begin
          ph_nx  = PH_SETUP;
          cnt_nx = CW'(SETUP_CYC - 1);
        end else begin
          ph_nx  = PH_IDLE;
        end
      end
      default: begin
        ph_nx  = PH_IDLE;
        cnt_nx = '0;
      end
    endcase
  end

  assign active = (ph == PH_SETUP) ||
                  (ph == PH_STROBE) ||
                  (ph == PH_HOLD);
  assign cs_n  = !active;
  assign wr_n  = !(ph == PH_STROBE && !cur.rd);
  assign rd_n  = !(ph == PH_STROBE && cur.rd);
  assign a0    = cur.a0;
  assign d_out = cur.d;
  assign d_oe  = active && !cur.rd;
  assign done  = (ph == PH_RECOV);

endmodule

// File: rtl/pic_host_bus_initiator.sv
// pic_host_bus_initiator: turns host commands into 8259 bus cycles.
// Ports: cmd_valid/ready/op/data, icw1..icw4 in; rsp_valid/data,
// cmd_err, init_done out; cs_n/wr_n/rd_n/a0/d_out/d_oe, d_in bus.
module pic_host_bus_initiator
  import pic_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       cmd_err,
  output logic       init_done,
  output logic       cs_n,
  output logic       wr_n,
  output logic       rd_n,
  output logic       a0,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in
);

  state_t           st, st_nx;
  bus_op_t [3:0]    plan, plan_q;
  logic [1:0]       n_last, last_q, idx;
  logic             is_init_q;
  logic             init_q;
  logic             accept, bad, go;
  logic             start, done, fin;
  bus_op_t          bop;

  assign cmd_ready = (st == ST_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign bad       = (cmd_op == OP_RSVD) ||
                     (cmd_op != OP_INIT && !init_q);
  assign go        = accept && !bad;
  assign fin       = (st == ST_BUSY) && done &&
                     (idx == last_q);

  // bus cycle list for the command, packed from slot 0
  always_comb begin
    plan   = '0;
    n_last = 2'd0;
    unique case (1'b1)
      (cmd_op == OP_INIT): begin
        plan[0] = '{1'b0, 1'b0, icw1 | ICW1_SET};
        plan[1] = '{1'b0, 1'b1, icw2};
        n_last  = 2'd1;
        if (!icw1[ICW1_SNGL]) begin
          n_last       = n_last + 2'd1;
          plan[n_last] = '{1'b0, 1'b1, icw3};
        end
        if (icw1[ICW1_IC4]) begin
          n_last       = n_last + 2'd1;
          plan[n_last] = '{1'b0, 1'b1, icw4};
        end
      end
      (cmd_op == OP_OCW1): begin
        plan[0] = '{1'b0, 1'b1, cmd_data};
      end
      (cmd_op == OP_OCW2): begin
        plan[0] = '{1'b0, 1'b0, cmd_data & OCW2_KEEP};
      end
      (cmd_op == OP_OCW3): begin
        plan[0] = '{1'b0, 1'b0,
                    (cmd_data & OCW3_KEEP) | OCW3_SET};
      end
      (cmd_op == OP_RD_IRR): begin
        plan[0] = '{1'b0, 1'b0, OCW3_RR_IRR};
        plan[1] = '{1'b1, 1'b0, 8'h00};
        n_last  = 2'd1;
      end
      (cmd_op == OP_RD_ISR): begin
        plan[0] = '{1'b0, 1'b0, OCW3_RR_ISR};
        plan[1] = '{1'b1, 1'b0, 8'h00};
        n_last  = 2'd1;
      end
      (cmd_op == OP_RD_IMR): begin
        plan[0] = '{1'b1, 1'b1, 8'h00};
      end
      default: begin
        plan   = '0;
        n_last = 2'd0;
      end
    endcase
  end

  assign start = (st == ST_IDLE && go) ||
                 (st == ST_BUSY && done && idx != last_q);
  assign bop   = (st == ST_IDLE) ? plan[0]
                                 : plan_q[idx + 2'd1];

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_IDLE;
      plan_q    <= '0;
      last_q    <= '0;
      idx       <= '0;
      is_init_q <= 1'b0;
      init_q    <= 1'b0;
    end else begin
      st <= st_nx;
      if (st == ST_IDLE && go) begin
        plan_q    <= plan;
        last_q    <= n_last;
        idx       <= '0;
        is_init_q <= (cmd_op == OP_INIT);
        if (cmd_op == OP_INIT)
          init_q <= 1'b0;
      end
      if (st == ST_BUSY && done) begin
        if (idx != last_q)
          idx <= idx + 2'd1;
        else if (is_init_q)
          init_q <= 1'b1;
      end
    end
  end

  always_comb begin
    st_nx = st;
    unique case (st)
      ST_IDLE: begin
        if (accept)
          st_nx = bad ? ST_ERR : ST_BUSY;
      end
      ST_ERR:  st_nx = ST_IDLE;
      ST_BUSY: begin
        if (fin)
          st_nx = ST_IDLE;
      end
      default: st_nx = ST_IDLE;
    endcase
  end

  assign cmd_err = (st == ST_ERR);
  // visible already in the RECOV clock of the last ICW cycle
  assign init_done = init_q || (fin && is_init_q);

  pic_bus_cycle #(
    .SETUP_CYC (SETUP_CYC),
    .STROBE_CYC(STROBE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_cyc (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (bop),
    .d_in  (d_in),
    .cs_n  (cs_n),
    .wr_n  (wr_n),
    .rd_n  (rd_n),
    .a0    (a0),
    .d_out (d_out),
    .d_oe  (d_oe),
    .rdata (rsp_data),
    .rvalid(rsp_valid),
    .done  (done)
  );

endmodule

// File: tb/tb_pic_host_bus_initiator.sv
// Bench for pic_host_bus_initiator: directed and random commands
// checked per clock against a command-level bus model.
module tb_pic_host_bus_initiator;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_valid2;
  logic       cmd_ready, cmd_ready2;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic [7:0] icw1, icw2, icw3, icw4;
  logic       rsp_valid, rsp_valid2;
  logic [7:0] rsp_data, rsp_data2;
  logic       cmd_err, cmd_err2;
  logic       init_done, init_done2;
  logic       cs_n, wr_n, rd_n, a0, d_oe;
  logic       cs_n2, wr_n2, rd_n2, a02, d_oe2;
  logic [7:0] d_out, d_out2;
  logic [7:0] d_in;

  always #5 clk = ~clk;

  pic_host_bus_initiator dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .cmd_err(cmd_err), .init_done(init_done),
    .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n), .a0(a0),
    .d_out(d_out), .d_oe(d_oe), .d_in(d_in)
  );

  pic_host_bus_initiator #(
    .SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)
  ) dut2 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
    .cmd_err(cmd_err2), .init_done(init_done2),
    .cs_n(cs_n2), .wr_n(wr_n2), .rd_n(rd_n2), .a0(a02),
    .d_out(d_out2), .d_oe(d_oe2), .d_in(d_in)
  );

  int vectors = 0;
  int fails   = 0;

  logic       m_init;
  logic [7:0] m_rsp;
  logic [9:0] exp_q[$];
  logic       exp_err, exp_rd, exp_init;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // expected bus cycles {rd, a0, data} from command rules
  task automatic build_exp(input logic [2:0] op,
                           input logic [7:0] cd);
    exp_q.delete();
    exp_err  = (op == 3'd7) || (op != 3'd0 && !m_init);
    exp_rd   = 1'b0;
    exp_init = 1'b0;
    if (!exp_err) begin
      case (op)
        3'd0: begin
          exp_init = 1'b1;
          exp_q.push_back({2'b00, icw1 | 8'h10});
          exp_q.push_back({2'b01, icw2});
          if (icw1[1] == 1'b0)
            exp_q.push_back({2'b01, icw3});
          if (icw1[0] == 1'b1)
            exp_q.push_back({2'b01, icw4});
        end
        3'd1: exp_q.push_back({2'b01, cd});
        3'd2: exp_q.push_back({2'b00, cd & 8'hE7});
        3'd3: exp_q.push_back({2'b00,
                               (cd & 8'h67) | 8'h08});
        3'd4: begin
          exp_q.push_back({2'b00, 8'h0A});
          exp_q.push_back({2'b10, 8'h00});
        end
        3'd5: begin
          exp_q.push_back({2'b00, 8'h0B});
          exp_q.push_back({2'b10, 8'h00});
        end
        default: exp_q.push_back({2'b11, 8'h00});
      endcase
      exp_rd = (op >= 3'd4);
    end
  endtask

  task automatic run_cmd(input logic [2:0] op,
                         input logic [7:0] cd,
                         input logic [7:0] din);
    int bad, fin, rsp_cnt, rsp_clk, err_cnt, err_clk;
    int id_clk, ci, p, nc;
    logic id1, act, ew, er;
    logic [7:0] rsp_val;
    logic [9:0] e, got;
    build_exp(op, cd);
    nc = exp_q.size();
    bad = 0; fin = 0; rsp_cnt = 0; rsp_clk = 0;
    err_cnt = 0; err_clk = 0; id_clk = 0; id1 = 1'b1;
    rsp_val = 8'h00;
    d_in = din;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = cd;
    chk("ready_idle", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      ci  = (n - 1) / 5;
      p   = (n - 1) % 5;
      e   = (ci < nc) ? exp_q[ci] : 10'h000;
      act = (ci < nc) && (p < 4);
      ew  = act && !e[9] && (p == 1 || p == 2);
      er  = act && e[9] && (p == 1 || p == 2);
      if (cs_n !== !act) bad++;
      if (wr_n !== !ew) bad++;
      if (rd_n !== !er) bad++;
      if (d_oe !== (act && !e[9])) bad++;
      if (act && a0 !== e[8]) bad++;
      if (act && !e[9] && d_out !== e[7:0]) bad++;
      if (!exp_init && init_done !== m_init) bad++;
      if (act && p == 1) begin
        got = {!rd_n, a0, rd_n ? d_out : 8'h00};
        chk("txn", got, e);
      end
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_clk = n;
        rsp_val = rsp_data;
      end
      if (cmd_err) begin
        err_cnt++;
        err_clk = n;
      end
      if (n == 1) id1 = init_done;
      if (init_done && id_clk == 0) id_clk = n;
      if (cmd_ready) begin
        fin = n;
        break;
      end
    end
    chk("done_clk", fin, exp_err ? 2 : 5 * nc + 1);
    chk("bus_timing", bad, 0);
    chk("err_cnt", err_cnt, {31'd0, exp_err});
    if (exp_err) chk("err_clk", err_clk, 1);
    chk("rsp_cnt", rsp_cnt, {31'd0, exp_rd});
    if (exp_rd) begin
      chk("rsp_clk", rsp_clk, 5 * nc);
      chk("rsp_data", rsp_val, din);
      m_rsp = din;
    end
    chk("rsp_hold", rsp_data, m_rsp);
    if (exp_init) begin
      chk("init_clr", id1, 0);
      chk("init_clk", id_clk, 5 * nc);
      m_init = 1'b1;
    end
  endtask

  initial begin
    int fin2, f1;
    logic [31:0] wrl, wre, csl, cse;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_valid2 = 1'b0;
    cmd_op = 3'd0; cmd_data = 8'h00;
    icw1 = 8'h00; icw2 = 8'h00; icw3 = 8'h00; icw4 = 8'h00;
    d_in = 8'h00;
    m_init = 1'b0;
    m_rsp  = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ctl", {cs_n, wr_n, rd_n, a0, d_oe}, 5'b11100);
    chk("rst_dout", d_out, 8'h00);
    chk("rst_rsp", {rsp_valid, rsp_data}, 9'h000);
    chk("rst_flags", {cmd_err, init_done, cmd_ready}, 3'b001);

    run_cmd(3'd1, 8'h55, 8'h00);
    run_cmd(3'd5, 8'h00, 8'h33);

    icw1 = 8'h13; icw2 = 8'h20; icw3 = 8'hEE; icw4 = 8'h01;
    run_cmd(3'd0, 8'h00, 8'h00);
    icw1 = 8'h11; icw3 = 8'h04;
    run_cmd(3'd0, 8'h00, 8'h00);
    icw1 = 8'h02;
    run_cmd(3'd0, 8'h00, 8'h00);

    run_cmd(3'd5, 8'h00, 8'h40);
    run_cmd(3'd6, 8'h00, 8'hF0);
    run_cmd(3'd4, 8'h00, 8'h81);
    run_cmd(3'd1, 8'hA5, 8'h00);
    run_cmd(3'd2, 8'h38, 8'h00);
    run_cmd(3'd3, 8'h9C, 8'h00);
    run_cmd(3'd7, 8'h12, 8'h00);

    for (int i = 0; i < 40; i++) begin
      icw1 = 8'($urandom);
      icw2 = 8'($urandom);
      icw3 = 8'($urandom);
      icw4 = 8'($urandom);
      run_cmd(3'($urandom_range(0, 7)),
              8'($urandom), 8'($urandom));
    end

    icw1 = 8'h13; icw2 = 8'h20; icw4 = 8'h01;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd0;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (7) @(negedge clk);
    chk("icw2_strobe", {cs_n, wr_n, a0, d_out}, {3'b001, 8'h20});
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ctl", {cs_n, wr_n, rd_n, d_oe}, 4'b1110);
    chk("abort_flags", {init_done, cmd_ready}, 2'b01);
    @(negedge clk);
    rst = 1'b0;
    m_init = 1'b0;
    m_rsp  = 8'h00;
    @(negedge clk);
    chk("abort_idle", {cs_n, init_done, cmd_ready}, 3'b101);
    run_cmd(3'd6, 8'h00, 8'h77);

    icw1 = 8'h12; icw2 = 8'h48;
    wrl = '0; csl = '0; wre = '0; cse = '0;
    fin2 = 0; f1 = 0;
    @(negedge clk);
    cmd_valid2 = 1'b1;
    cmd_op     = 3'd0;
    @(posedge clk);
    #1 cmd_valid2 = 1'b0;
    for (int n = 1; n <= 31; n++) begin
      @(negedge clk);
      wrl[n] = !wr_n2;
      csl[n] = !cs_n2;
      if (init_done2 && f1 == 0) f1 = n;
      if (cmd_ready2) begin
        fin2 = n;
        break;
      end
    end
    for (int n = 1; n <= 16; n++) begin
      wre[n] = ((n - 1) % 8 >= 2) && ((n - 1) % 8 <= 4);
      cse[n] = ((n - 1) % 8 < 7);
    end
    chk("p2_wr_n", wrl, wre);
    chk("p2_cs_n", csl, cse);
    chk("p2_done", fin2, 17);
    chk("p2_init", f1, 16);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule
